// File: rtl/mult_pkg.sv
// Shared definitions for the product accumulator: product width and FSM state encoding.
package mult_pkg;

    localparam int PROD_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accState_t;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Signed accumulator adder; saturating with an overflow flag when PRODUCT_ACC_SAT_EN is defined,
// plain modulo-2^ACC_W wrap with ovf_o tied low otherwise.
module sat_add
    import mult_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]  a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] bExt;

    assign bExt = {{(ACC_W-PROD_W){b_i[PROD_W-1]}}, b_i};

`ifdef PRODUCT_ACC_SAT_EN
    logic [ACC_W:0] wide;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    always_comb begin
        wide  = {a_i[ACC_W-1], a_i} + {bExt[ACC_W-1], bExt};
        ovf_o = wide[ACC_W] ^ wide[ACC_W-1];
        sum_o = wide[ACC_W-1:0];
        if (ovf_o) begin
            sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        sum_o = a_i + bExt;
        ovf_o = 1'b0;
    end
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS signed 9-bit products into an ACC_W-bit result behind valid/ready handshakes.
// Optional saturation with sticky overflow: define PRODUCT_ACC_SAT_EN.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] prod_in,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              overflow
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_TERMS - 1);

    accState_t        state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] addSum;
    logic             addOvf;

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a_i   (acc_q),
        .b_i   (prod_in),
        .sum_o (addSum),
        .ovf_o (addOvf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // start only matters in IDLE; ACCUM and DONE never look at it.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = addSum;
                    ovf_d   = ovf_q | addOvf;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance plus an ACC_W=10 instance for the overflow case.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, inValid, outReady;
    logic [8:0]  prodIn;
    logic        inReady, outValid, busy, overflow;
    logic [15:0] accOut;

    logic        start10, inValid10, outReady10;
    logic [8:0]  prodIn10;
    logic        inReady10, outValid10, busy10, overflow10;
    logic [9:0]  accOut10;

    int checkCount = 0;
    int passCount  = 0;

`ifdef PRODUCT_ACC_SAT_EN
    localparam logic [9:0] EXP_ACC10 = 10'd511;
    localparam logic       EXP_OVF10 = 1'b1;
`else
    localparam logic [9:0] EXP_ACC10 = 10'h280;
    localparam logic       EXP_OVF10 = 1'b0;
`endif

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (inValid),
        .prod_in   (prodIn),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_ready (outReady),
        .acc_out   (accOut),
        .busy      (busy),
        .overflow  (overflow)
    );

    product_accumulator #(.N_TERMS(10), .ACC_W(10)) dut10 (
        .clk       (clk),
        .rst       (rst),
        .start     (start10),
        .in_valid  (inValid10),
        .prod_in   (prodIn10),
        .in_ready  (inReady10),
        .out_valid (outValid10),
        .out_ready (outReady10),
        .acc_out   (accOut10),
        .busy      (busy10),
        .overflow  (overflow10)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checkCount++;
        if ({inReady, outValid, busy, overflow} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {inReady, outValid, busy, overflow});
        else passCount++;
        checkCount++;
        if (accOut !== 16'd0) $display("[TB] FAIL reset_acc: got %0h expected 0", accOut);
        else passCount++;
        checkCount++;
        if ({inReady10, outValid10, busy10, overflow10, accOut10} !== 14'd0)
            $display("[TB] FAIL reset_dut10: got %0h expected 0", {inReady10, outValid10, busy10, overflow10, accOut10});
        else passCount++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkCount++;
        if ({busy, inReady, outValid} !== 3'b110)
            $display("[TB] FAIL start_flags: got %b expected 110", {busy, inReady, outValid});
        else passCount++;
    endtask

    task automatic test_back_to_back();
        inValid = 1'b1;
        prodIn  = 9'd64;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) begin
                checkCount++;
                if ({outValid, accOut} !== {1'b0, 16'd448})
                    $display("[TB] FAIL b2b_seventh: got valid=%b acc=%0d expected valid=0 acc=448", outValid, accOut);
                else passCount++;
            end
        end
        inValid = 1'b0;
        checkCount++;
        if ({outValid, inReady} !== 2'b10)
            $display("[TB] FAIL b2b_done_flags: got %b expected 10", {outValid, inReady});
        else passCount++;
        checkCount++;
        if (accOut !== 16'd512) $display("[TB] FAIL b2b_acc: got %0d expected 512", accOut);
        else passCount++;
        checkCount++;
        if (overflow !== 1'b0) $display("[TB] FAIL b2b_ovf: got %b expected 0", overflow);
        else passCount++;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkCount++;
        if ({busy, outValid, accOut} !== {2'b00, 16'd512})
            $display("[TB] FAIL b2b_idle: got busy=%b valid=%b acc=%0d expected 0 0 512", busy, outValid, accOut);
        else passCount++;
    endtask

    task automatic test_stalls();
        int running = 0;
        logic [15:0] expAcc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prodIn  = (i % 2 == 0) ? 9'(-56) : 9'd64;
            running += (i % 2 == 0) ? -56 : 64;
            inValid = 1'b1;
            tick();
            inValid = 1'b0;
            prodIn  = 9'h0FF;
            expAcc  = 16'(running);
            for (int g = 0; g < 3; g++) tick();
            checkCount++;
            if (accOut !== expAcc)
                $display("[TB] FAIL stall_acc_%0d: got %0h expected %0h", i, accOut, expAcc);
            else passCount++;
            checkCount++;
            if (outValid !== (i == 7))
                $display("[TB] FAIL stall_valid_%0d: got %b expected %b", i, outValid, (i == 7));
            else passCount++;
        end
        checkCount++;
        if (accOut !== 16'd32) $display("[TB] FAIL stall_final: got %0d expected 32", accOut);
        else passCount++;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_done_hold();
        start = 1'b1;
        tick();
        start   = 1'b0;
        inValid = 1'b1;
        prodIn  = 9'd100;
        for (int i = 0; i < 8; i++) tick();
        inValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            tick();
            checkCount++;
            if ({outValid, busy, accOut} !== {2'b11, 16'd800})
                $display("[TB] FAIL hold_%0d: got valid=%b busy=%b acc=%0d expected 1 1 800", i, outValid, busy, accOut);
            else passCount++;
        end
        start    = 1'b1;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        start    = 1'b0;
        checkCount++;
        if ({busy, outValid} !== 2'b00)
            $display("[TB] FAIL hold_exit: got %b expected 00", {busy, outValid});
        else passCount++;
        tick();
        checkCount++;
        if ({busy, accOut} !== {1'b0, 16'd800})
            $display("[TB] FAIL hold_no_restart: got busy=%b acc=%0d expected 0 800", busy, accOut);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start   = 1'b0;
        inValid = 1'b1;
        prodIn  = 9'd10;
        for (int i = 0; i < 4; i++) tick();
        inValid = 1'b0;
        checkCount++;
        if (accOut !== 16'd40) $display("[TB] FAIL mid_partial: got %0d expected 40", accOut);
        else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if ({inReady, outValid, busy, overflow, accOut} !== 20'd0)
            $display("[TB] FAIL mid_reset: got %0h expected 0", {inReady, outValid, busy, overflow, accOut});
        else passCount++;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL mid_first_start: got %b expected 1", busy);
        else passCount++;
        inValid = 1'b1;
        prodIn  = 9'h1FF;
        for (int i = 0; i < 8; i++) tick();
        inValid = 1'b0;
        checkCount++;
        if ({outValid, accOut} !== {1'b1, 16'hFFF8})
            $display("[TB] FAIL mid_neg_sum: got valid=%b acc=%0h expected 1 fff8", outValid, accOut);
        else passCount++;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_width10();
        start10 = 1'b1;
        tick();
        start10   = 1'b0;
        inValid10 = 1'b1;
        prodIn10  = 9'd64;
        for (int i = 0; i < 10; i++) tick();
        inValid10 = 1'b0;
        checkCount++;
        if ({outValid10, accOut10} !== {1'b1, EXP_ACC10})
            $display("[TB] FAIL w10_acc: got valid=%b acc=%0h expected 1 %0h", outValid10, accOut10, EXP_ACC10);
        else passCount++;
        checkCount++;
        if (overflow10 !== EXP_OVF10)
            $display("[TB] FAIL w10_ovf: got %b expected %b", overflow10, EXP_OVF10);
        else passCount++;
        outReady10 = 1'b1;
        tick();
        outReady10 = 1'b0;
        checkCount++;
        if ({busy10, accOut10} !== {1'b0, EXP_ACC10})
            $display("[TB] FAIL w10_idle: got busy=%b acc=%0h expected 0 %0h", busy10, accOut10, EXP_ACC10);
        else passCount++;
    endtask

    initial begin
        start      = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b0;
        prodIn     = '0;
        start10    = 1'b0;
        inValid10  = 1'b0;
        outReady10 = 1'b0;
        prodIn10   = '0;
        test_reset();
        test_start();
        test_back_to_back();
        test_stalls();
        test_done_hold();
        test_reset_mid();
        test_width10();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
